hazard_match_pipe: RTL

- Tracks register addresses and write-enable control through the Execute, Memory and Writeback stages.
- Produces the five Match_* comparison flags, plus RegWriteM, RegWriteW and MemToRegE, consumed directly by HazardUnit.
- Consumes HazardUnit's FlushE to insert a bubble in the Execute slot.
- Sits beside the datapath pipeline registers, upstream of HazardUnit.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_match_pipe_if.sv | 37 +++
 rtl/hz_stage_reg.sv | 23 ++
 rtl/hazard_match_pipe.sv | 84 ++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared widths, the never-forwarded register index, stage field layouts and
// the source/destination comparison used by every hazard match.
package hazard_pkg;

    localparam int REG_ADDR_W = 4;
    localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

    // Destination side of a stage: where it writes and whether it writes.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic                  regwrite;
    } stage_ctl_t;

    // Source side of the Execute stage.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] ra1;
        logic [REG_ADDR_W-1:0] ra2;
        logic                  use1;
        logic                  use2;
    } e_src_t;

    typedef struct packed {
        e_src_t     src;
        stage_ctl_t ctl;
        logic       memtoreg;
    } e_stage_t;

    // A read hits a stage only if the source is really read, the stage writes
    // the same register, and that register is not the PC.
    function automatic logic src_hit(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] ra,
        input stage_ctl_t            dst
    );
        return use_src & dst.regwrite & (ra == dst.waddr) & (ra != PC_REG);
    endfunction

endpackage

// File: rtl/hazard_match_pipe_if.sv
// Decode-side inputs, HazardUnit flush and the match/control flags going back
// to HazardUnit, bundled as one bus.
interface hazard_match_pipe_if;
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] RA1D;
    logic [REG_ADDR_W-1:0] RA2D;
    logic                  Use1D;
    logic                  Use2D;
    logic [REG_ADDR_W-1:0] WA3D;
    logic                  RegWriteD;
    logic                  MemToRegD;
    logic                  FlushE;

    logic Match_1E_M;
    logic Match_1E_W;
    logic Match_2E_M;
    logic Match_2E_W;
    logic Match_12D_E;
    logic RegWriteM;
    logic RegWriteW;
    logic MemToRegE;

    // Upstream side: decode stage plus HazardUnit.
    modport master (
        output RA1D, RA2D, Use1D, Use2D, WA3D, RegWriteD, MemToRegD, FlushE,
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  RegWriteM, RegWriteW, MemToRegE
    );

    modport slave (
        input  RA1D, RA2D, Use1D, Use2D, WA3D, RegWriteD, MemToRegD, FlushE,
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output RegWriteM, RegWriteW, MemToRegE
    );

endinterface

// File: rtl/hz_stage_reg.sv
// Pipeline stage register: asynchronous active-low clear for reset, plus a
// synchronous clear used to load a bubble.
module hz_stage_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_match_pipe.sv
// Carries register addresses and write controls through E/M/W and produces the
// forwarding and load-use match flags for HazardUnit.
module hazard_match_pipe
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_match_pipe_if.slave    bus
);

    e_stage_t   e_d;
    e_stage_t   e_q;
    stage_ctl_t m_q;
    stage_ctl_t w_q;

    assign e_d.src.ra1        = bus.RA1D;
    assign e_d.src.ra2        = bus.RA2D;
    assign e_d.src.use1       = bus.Use1D;
    assign e_d.src.use2       = bus.Use2D;
    assign e_d.ctl.waddr      = bus.WA3D;
    assign e_d.ctl.regwrite   = bus.RegWriteD;
    assign e_d.memtoreg       = bus.MemToRegD;

    // FlushE only reaches the E register, so no output depends on it directly.
    hz_stage_reg #(.WIDTH($bits(e_stage_t))) u_stage_e (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (bus.FlushE),
        .d     (e_d),
        .q     (e_q)
    );

    hz_stage_reg #(.WIDTH($bits(stage_ctl_t))) u_stage_m (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (1'b0),
        .d     (e_q.ctl),
        .q     (m_q)
    );

    hz_stage_reg #(.WIDTH($bits(stage_ctl_t))) u_stage_w (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (1'b0),
        .d     (m_q),
        .q     (w_q)
    );

    // Index 0 is source 1, index 1 is source 2.
    logic [1:0]            use_e;
    logic [1:0]            use_d;
    logic [REG_ADDR_W-1:0] ra_e [2];
    logic [REG_ADDR_W-1:0] ra_d [2];
    logic [1:0]            match_m;
    logic [1:0]            match_w;
    logic [1:0]            match_d;

    assign use_e = {e_q.src.use2, e_q.src.use1};
    assign use_d = {bus.Use2D, bus.Use1D};
    assign ra_e[0] = e_q.src.ra1;
    assign ra_e[1] = e_q.src.ra2;
    assign ra_d[0] = bus.RA1D;
    assign ra_d[1] = bus.RA2D;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign match_m[gi] = src_hit(use_e[gi], ra_e[gi], m_q);
            assign match_w[gi] = src_hit(use_e[gi], ra_e[gi], w_q);
            assign match_d[gi] = src_hit(use_d[gi], ra_d[gi], e_q.ctl);
        end
    endgenerate

    // M and W matches are reported independently; HazardUnit picks priority.
    assign bus.Match_1E_M  = match_m[0];
    assign bus.Match_1E_W  = match_w[0];
    assign bus.Match_2E_M  = match_m[1];
    assign bus.Match_2E_W  = match_w[1];
    assign bus.Match_12D_E = |match_d;
    assign bus.RegWriteM   = m_q.regwrite;
    assign bus.RegWriteW   = w_q.regwrite;
    assign bus.MemToRegE   = e_q.memtoreg;

endmodule
